onehot_add_pipe: RTL and testbench
==================================

# onehot_add_pipe

Parametrised, pipelined radix-4 one-hot adder/subtractor, the next generation of the 16-bit one-hot digit adder. Binary operands are converted to one-hot radix-4 digits (4 lines per 2 bits), summed digit-wise by one-hot digit adders with a carry chain broken into pipeline stages, then converted back to binary. Sits between the register-file read path and the result writeback, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 16, binary operand/result width; even, ≥ 4; digit count D = WIDTH/2
- STAGE_DIGITS, 2, one-hot digits resolved per pipeline stage, 1..D; stage count N = ceil(D/STAGE_DIGITS)

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand beat offered
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A, binary
- b  in  WIDTH  operand B, binary
- sub  in  1  0: sum = a+b+cin; 1: sum = a−b−cin
- cin  in  1  carry-in (add) / borrow-in (sub)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, binary, modulo 2^WIDTH
- cout  out  1  add: carry out of bit WIDTH−1; sub: borrow out (1 when a < b+cin, unsigned)

## Operation
- Input conversion: 2-bit binary digit v maps to one-hot line v (00→line0 … 11→line3).
- Subtract: the one-hot B digit is reversed (line i → line 3−i, i.e. d → 3−d); internal carry-in = ~cin; reported cout = ~internal carry.
- Digit adder: the digit sum of two one-hot digits plus carry gives a one-hot result digit and a carry. Every internal digit vector is exactly one-hot.
- Stage k (0..N−1) adds digits [k·S, k·S+S−1] (S = STAGE_DIGITS; last stage may be short) using the carry registered from stage k−1. Stage 0 uses the internal carry-in.
- Unprocessed upper digits of A/B and already-resolved lower result digits travel in per-stage pipeline registers, together with a valid bit.
- Output conversion: one-hot result digit → 2-bit binary. sum and cout are registered outputs of stage N−1.
- Flow control: global enable en = !out_valid | out_ready. in_ready = en. When en=1 all stages advance, and a beat is accepted iff in_valid & in_ready. When en=0 all pipeline registers hold. Bubbles propagate as valid=0.
- No combinational path from in_valid/a/b to out_*. in_ready depends combinationally on out_ready.

## Timing
- Reset (asynchronous assertion, synchronous-safe release): all stage valid bits 0, out_valid=0, sum=0, cout=0, all data registers 0. in_ready=1 while rst_n=1 and out_valid=0.
- Latency: a beat accepted at edge t presents out_valid=1 with its result after edge t+N. Default N=4.
- Throughput: 1 beat/cycle when out_ready is held at 1.
- Stall: while out_valid=1 & out_ready=0, sum/cout/out_valid are stable and in_ready=0. No beat is dropped or duplicated. Results leave in acceptance order.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: one beat leaves and one enters on the same edge.
- Reset mid-operation: all in-flight beats are discarded. The first output after release comes from a beat accepted after release.
- Wrap-around: sum is modulo 2^WIDTH; overflow is reported only via cout.

## Test plan
- WIDTH=16, S=2: a=0xFFFF, b=0x0001, sub=0, cin=0 → after 4 cycles sum=0x0000, cout=1; a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=1; a=0x8000, b=0x0001, sub=1, cin=1 → sum=0x7FFE, cout=0.
- Streaming: 64 random beats back-to-back, out_ready=1 → 64 outputs in order, each matches the reference model, output gap 0 after the first 4-cycle latency.
- Backpressure: out_ready=0 for 3 cycles with the pipeline full → in_ready=0 and sum held for those 3 cycles; after release all beats arrive exactly once, in order.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0, sum=0 immediately (asynchronously); after release, no stale beat is output.
- Parameter sweep: WIDTH=8, S=3 (N=2): a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1 after 2 cycles. WIDTH=32, S=1 (N=16): exhaustive carry-ripple case 0xFFFFFFFF+0+cin=1 → sum=0, cout=1 after 16 cycles.

Source files
------------

// File: rtl/onehot_add_pipe_if.sv
// Operand/result handshake bundle for the one-hot adder pipe.
// master drives operands and out_ready; slave is the adder.
interface onehot_add_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/onehot_add_pipe.sv
// Pipelined radix-4 one-hot adder/subtractor.
// Carry chain split into N stages of STAGE_DIGITS digits each.
module onehot_add_pipe #(
  parameter int WIDTH        = 16,
  parameter int STAGE_DIGITS = 2
) (
  input  logic clk,
  input  logic rst_n,
  onehot_add_pipe_if.slave bus
);
  localparam int D = WIDTH / 2;
  localparam int S = STAGE_DIGITS;
  localparam int N = (D + S - 1) / S;

  typedef logic [3:0] oh_t;

  function automatic oh_t bin2oh(input logic [1:0] v);
    return oh_t'(4'b0001 << v);
  endfunction

  function automatic oh_t rev(input oh_t x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [1:0] oh2bin(input oh_t x);
    return {x[3] | x[2], x[3] | x[1]};
  endfunction

  // {carry, one-hot digit}; digit sum 0..7 folds onto lines 0..3
  function automatic logic [4:0] oh_add(
    input oh_t  x,
    input oh_t  y,
    input logic c
  );
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        t[i+j] = t[i+j] | (x[i] & y[j]);
      end
    end
    if (c) t = {t[6:0], 1'b0};
    return {|t[7:4], t[3:0] | t[7:4]};
  endfunction

  oh_t a_q [N][D];
  oh_t b_q [N][D];
  oh_t r_q [N][D];
  oh_t r_d [N][D];

  logic [N-1:0]     v_q;
  logic [N-1:0]     c_q;
  logic [N-1:0]     s_q;
  logic [N-1:0]     cy_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             out_valid_q;
  logic             en;

  assign en            = !out_valid_q | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_comb begin
    cy_d = c_q;
    for (int k = 0; k < N; k++) begin
      for (int d = 0; d < D; d++) begin
        r_d[k][d] = r_q[k][d];
        if (d / S == k) begin
          {cy_d[k], r_d[k][d]} =
            oh_add(a_q[k][d], b_q[k][d], cy_d[k]);
        end
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int d = 0; d < D; d++) begin
      sum_d[2*d +: 2] = oh2bin(r_d[N-1][d]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        for (int d = 0; d < D; d++) begin
          a_q[k][d] <= '0;
          b_q[k][d] <= '0;
          r_q[k][d] <= '0;
        end
      end
      v_q         <= '0;
      c_q         <= '0;
      s_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      v_q[0] <= bus.in_valid;
      if (bus.in_valid) begin
        for (int d = 0; d < D; d++) begin
          a_q[0][d] <= bin2oh(bus.a[2*d +: 2]);
          b_q[0][d] <= bus.sub ? rev(bin2oh(bus.b[2*d +: 2]))
                               : bin2oh(bus.b[2*d +: 2]);
          r_q[0][d] <= '0;
        end
        // subtract runs as a + ~b + 1 - borrow
        c_q[0] <= bus.cin ^ bus.sub;
        s_q[0] <= bus.sub;
      end
      for (int k = 1; k < N; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          for (int d = 0; d < D; d++) begin
            a_q[k][d] <= a_q[k-1][d];
            b_q[k][d] <= b_q[k-1][d];
            r_q[k][d] <= r_d[k-1][d];
          end
          c_q[k] <= cy_d[k-1];
          s_q[k] <= s_q[k-1];
        end
      end
      out_valid_q <= v_q[N-1];
      if (v_q[N-1]) begin
        sum_q  <= sum_d;
        cout_q <= cy_d[N-1] ^ s_q[N-1];
      end
    end
  end
endmodule

// File: tb/tb_onehot_add_pipe.sv
// Random + directed bench for onehot_add_pipe against an arithmetic model.
// Also exercises WIDTH=8/S=3 and WIDTH=32/S=1 instances.
module tb_onehot_add_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ocnt = 0;
  logic lat_on = 1'b0;
  logic stall_p = 1'b0;
  logic [16:0] hs;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          t;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  onehot_add_pipe_if #(.WIDTH(16)) b16();
  onehot_add_pipe_if #(.WIDTH(8))  b8();
  onehot_add_pipe_if #(.WIDTH(32)) b32();

  onehot_add_pipe #(.WIDTH(16), .STAGE_DIGITS(2)) u16 (
    .clk(clk), .rst_n(rst_n), .bus(b16)
  );
  onehot_add_pipe #(.WIDTH(8), .STAGE_DIGITS(3)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );
  onehot_add_pipe #(.WIDTH(32), .STAGE_DIGITS(1)) u32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // {cout, sum}: add carry-out, or unsigned borrow for subtract
  function automatic logic [16:0] model16(input logic [15:0] a,
      input logic [15:0] b, input logic s, input logic c);
    logic [16:0] t;
    if (!s) begin
      t = {1'b0, a} + {1'b0, b} + 17'(c);
    end else begin
      t[15:0] = a - b - 16'(c);
      t[16]   = ({1'b0, a} < ({1'b0, b} + 17'(c)));
    end
    return t;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", b16.out_valid, 1);
        chk("hold_data", {b16.cout, b16.sum}, hs);
      end
      if (b16.out_valid && !b16.out_ready)
        chk("stall_in_ready", b16.in_ready, 0);
      if (b16.out_valid && b16.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", b16.sum, e.s);
          chk("cout", b16.cout, e.c);
          if (lat_on) chk("latency", cyc - e.t, 5);
          ocnt++;
        end
      end
      if (b16.in_valid && b16.in_ready) begin
        exp_t e;
        logic [16:0] m;
        m = model16(b16.a, b16.b, b16.sub, b16.cin);
        e.s = m[15:0];
        e.c = m[16];
        e.t = cyc;
        q.push_back(e);
      end
      stall_p = b16.out_valid && !b16.out_ready;
      hs = {b16.cout, b16.sum};
    end
  end

  task automatic dir16(input string nm, input logic [15:0] a,
      input logic [15:0] b, input logic s, input logic c,
      input logic [15:0] es, input logic ec);
    int k;
    @(posedge clk); #1;
    b16.a = a; b16.b = b; b16.sub = s; b16.cin = c;
    b16.in_valid = 1'b1; b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    k = 0;
    while (!b16.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, k, 4);
    chk({nm, "_sum"}, b16.sum, es);
    chk({nm, "_cout"}, b16.cout, ec);
  endtask

  task automatic stream(input int n, input int bp_at, input int bp_len);
    int   i;
    int   c;
    logic acc;
    i = 0;
    c = 0;
    b16.a = 16'($urandom); b16.b = 16'($urandom);
    b16.sub = 1'($urandom); b16.cin = 1'($urandom);
    while (i < n && c < n + 200) begin
      b16.in_valid  = 1'b1;
      b16.out_ready = !(c >= bp_at && c < bp_at + bp_len);
      @(negedge clk);
      acc = b16.in_ready;
      @(posedge clk); #1;
      c++;
      if (acc) begin
        i++;
        b16.a = 16'($urandom); b16.b = 16'($urandom);
        b16.sub = 1'($urandom); b16.cin = 1'($urandom);
      end
    end
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    chk("stream_accepts", i, n);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    b16.in_valid = 0; b16.a = 0; b16.b = 0; b16.sub = 0;
    b16.cin = 0; b16.out_ready = 1;
    b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.sub = 0;
    b8.cin = 0; b8.out_ready = 1;
    b32.in_valid = 0; b32.a = 0; b32.b = 0; b32.sub = 0;
    b32.cin = 0; b32.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", b16.out_valid, 0);
    chk("rst_sum", b16.sum, 0);
    chk("rst_cout", b16.cout, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", b16.in_ready, 1);
    chk("rst8_in_ready", b8.in_ready, 1);
    chk("rst32_valid", b32.out_valid, 0);

    dir16("add_wrap", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1);
    dir16("add_cin", 16'h1234, 16'h4321, 0, 1, 16'h5556, 0);
    dir16("sub_neg", 16'h0005, 16'h0007, 1, 0, 16'hFFFE, 1);
    dir16("sub_bin", 16'h8000, 16'h0001, 1, 1, 16'h7FFE, 0);
    dir16("sub_eq", 16'h1234, 16'h1233, 1, 1, 16'h0000, 0);
    drain();

    ocnt = 0;
    lat_on = 1'b1;
    stream(64, 1000, 0);
    drain();
    lat_on = 1'b0;
    chk("stream_count", ocnt, 64);

    ocnt = 0;
    stream(12, 6, 3);
    drain();
    chk("bp_count", ocnt, 12);

    stream(6, 1000, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", b16.out_valid, 0);
    chk("mid_rst_sum", b16.sum, 0);
    chk("mid_rst_cout", b16.cout, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", b16.in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale", b16.out_valid, 0);
    end
    dir16("post_rst", 16'h00F0, 16'h000F, 0, 1, 16'h0100, 0);
    drain();

    for (int i = 0; i < 9; i++) begin
      logic [7:0] x;
      logic [7:0] y;
      logic       s;
      logic       c;
      logic [8:0] e;
      if (i == 0) begin
        x = 8'hFF; y = 8'hFF; s = 0; c = 1;
      end else begin
        x = 8'($urandom); y = 8'($urandom);
        s = 1'($urandom); c = 1'($urandom);
      end
      if (s) e = {({1'b0, x} < ({1'b0, y} + 9'(c))), 8'(x - y - 8'(c))};
      else   e = {1'b0, x} + {1'b0, y} + 9'(c);
      @(posedge clk); #1;
      b8.a = x; b8.b = y; b8.sub = s; b8.cin = c; b8.in_valid = 1;
      @(posedge clk); #1;
      b8.in_valid = 0;
      k = 0;
      while (!b8.out_valid && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      chk("w8_lat", k, 2);
      chk("w8_sum", b8.sum, e[7:0]);
      chk("w8_cout", b8.cout, e[8]);
      if (i == 0) begin
        chk("w8_lit_sum", b8.sum, 8'hFF);
        chk("w8_lit_cout", b8.cout, 1);
      end
    end

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      b32.a = (i == 0) ? 32'hFFFF_FFFF : 32'h0;
      b32.b = (i == 0) ? 32'h0 : 32'h1;
      b32.sub = (i != 0);
      b32.cin = (i == 0);
      b32.in_valid = 1;
      @(posedge clk); #1;
      b32.in_valid = 0;
      k = 0;
      while (!b32.out_valid && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      chk("w32_lat", k, 16);
      chk("w32_sum", b32.sum, (i == 0) ? 32'h0 : 32'hFFFF_FFFF);
      chk("w32_cout", b32.cout, 1);
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
